// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data memory between two req/ack requesters.
// The winning request is latched at the IDLE grant edge. The memory strobes are then
// held for LATENCY cycles, and the access completes with a one-cycle ack.
// Build option: define DMEM_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins
// ties). When it is undefined, ties are resolved round-robin.
module dmem_arbiter #(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned LATENCY = 2
) (
   input  logic              clk,
   input  logic              rst_i,
   input  logic              req0_i,
   input  logic              we0_i,
   input  logic [ADDR_W-1:0] addr0_i,
   input  logic [DATA_W-1:0] wdata0_i,
   input  logic              req1_i,
   input  logic              we1_i,
   input  logic [ADDR_W-1:0] addr1_i,
   input  logic [DATA_W-1:0] wdata1_i,
   output logic [1:0]        ack_o,
   output logic [DATA_W-1:0] rdata_o,
   output logic [1:0]        grant_o,
   output logic              busy_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   output logic              mem_read_o,
   output logic              mem_write_o,
   input  logic [DATA_W-1:0] mem_rdata_i
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BUSY,
      ST_RESP
   } state_t;

   state_t            state_q, state_d;
   logic [7:0]        cnt_q, cnt_d;
   logic [1:0]        grant_q, grant_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              pick1;
`ifndef DMEM_ARB_FIXED_PRIO_EN
   logic              last_grant_q, last_grant_d;
`endif

   // Winner selection: a lone request wins. A tie goes to requester 0 in the
   // fixed build, or otherwise to the requester that did not win last time.
   always_comb begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
      pick1 = req1_i & ~req0_i;
`else
      pick1 = req1_i & (~req0_i | ~last_grant_q);
`endif
   end

   // State register and transaction latches; reset aborts any transaction in flight.
   always_ff @(posedge clk or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         grant_q      <= '0;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         rdata_q      <= '0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
         last_grant_q <= 1'b1;
`endif
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         grant_q      <= grant_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         rdata_q      <= rdata_d;
`ifndef DMEM_ARB_FIXED_PRIO_EN
         last_grant_q <= last_grant_d;
`endif
      end
   end

   // Next state: grant and latch in IDLE, count down in BUSY, one-cycle RESP.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      grant_d      = grant_q;
      we_d         = we_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      rdata_d      = rdata_q;
`ifndef DMEM_ARB_FIXED_PRIO_EN
      last_grant_d = last_grant_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (req0_i | req1_i) begin
               state_d = ST_BUSY;
               cnt_d   = 8'(LATENCY - 1);
               if (pick1) begin
                  grant_d = 2'b10;
                  we_d    = we1_i;
                  addr_d  = addr1_i;
                  wdata_d = wdata1_i;
               end else begin
                  grant_d = 2'b01;
                  we_d    = we0_i;
                  addr_d  = addr0_i;
                  wdata_d = wdata0_i;
               end
`ifndef DMEM_ARB_FIXED_PRIO_EN
               last_grant_d = pick1;
`endif
            end
         end
         ST_BUSY: begin
            if (cnt_q == 8'd0) begin
               state_d = ST_RESP;
               if (!we_q) rdata_d = mem_rdata_i;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs are decoded from the state. Reset therefore clears them without waiting for a clock edge.
   always_comb begin
      busy_o      = (state_q != ST_IDLE);
      grant_o     = busy_o ? grant_q : '0;
      ack_o       = (state_q == ST_RESP) ? grant_q : '0;
      mem_addr_o  = (state_q == ST_BUSY) ? addr_q : '0;
      mem_wdata_o = (state_q == ST_BUSY) ? wdata_q : '0;
      mem_read_o  = (state_q == ST_BUSY) & ~we_q;
      mem_write_o = (state_q == ST_BUSY) & we_q;
      rdata_o     = rdata_q;
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter. The stimulus pushes expected transactions into a
// scoreboard queue, and a negedge monitor checks the memory bus and the acks against it.
// A second instance with LATENCY=1 is checked directly in the last test.
module tb_dmem_arbiter;
   localparam int unsigned LAT = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
   logic [31:0] addr0 = '0, wdata0 = '0, addr1 = '0, wdata1 = '0;
   logic [31:0] mem_rdata = '0;

   logic [1:0]  ack_o, grant_o;
   logic [31:0] rdata_o, mem_addr_o, mem_wdata_o;
   logic        busy_o, mem_read_o, mem_write_o;

   logic [1:0]  ack_b, grant_b;
   logic [31:0] rdata_b, mem_addr_b, mem_wdata_b;
   logic        busy_b, read_b, write_b;

   always #5 clk = ~clk;

   dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(LAT)) u_dut (
      .clk(clk), .rst_i(rst),
      .req0_i(req0), .we0_i(we0), .addr0_i(addr0), .wdata0_i(wdata0),
      .req1_i(req1), .we1_i(we1), .addr1_i(addr1), .wdata1_i(wdata1),
      .ack_o(ack_o), .rdata_o(rdata_o), .grant_o(grant_o), .busy_o(busy_o),
      .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
      .mem_read_o(mem_read_o), .mem_write_o(mem_write_o), .mem_rdata_i(mem_rdata));

   dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(1)) u_dut1 (
      .clk(clk), .rst_i(rst),
      .req0_i(req0), .we0_i(we0), .addr0_i(addr0), .wdata0_i(wdata0),
      .req1_i(req1), .we1_i(we1), .addr1_i(addr1), .wdata1_i(wdata1),
      .ack_o(ack_b), .rdata_o(rdata_b), .grant_o(grant_b), .busy_o(busy_b),
      .mem_addr_o(mem_addr_b), .mem_wdata_o(mem_wdata_b),
      .mem_read_o(read_b), .mem_write_o(write_b), .mem_rdata_i(mem_rdata));

   typedef struct {
      logic [1:0]  grant;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] exp_rdata = '0;
   int          n_checks = 0;
   int          n_fail = 0;
   int          cyc = 0;
   int          strb_cnt = 0;
   int          last_ack_cyc = -1;
   bit          chk_gap = 1'b0;

   function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
      end
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: checks the bus while strobes are active and retires one scoreboard entry per ack.
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         strb_cnt     = 0;
         last_ack_cyc = -1;
      end else begin
         check("rd_wr_excl", 64'(mem_read_o & mem_write_o), 64'd0);
         if (!busy_o)
            check("idle_outs", {26'd0, grant_o, ack_o, mem_read_o, mem_write_o, mem_addr_o}, 64'd0);
         if (mem_read_o | mem_write_o) begin
            strb_cnt++;
            if (exp_q.size() > 0) begin
               check("bus_grant", 64'(grant_o), 64'(exp_q[0].grant));
               check("bus_addr", 64'(mem_addr_o), 64'(exp_q[0].addr));
               check("bus_strobe", {62'd0, mem_write_o, mem_read_o},
                     exp_q[0].we ? 64'd2 : 64'd1);
               if (exp_q[0].we) check("bus_wdata", 64'(mem_wdata_o), 64'(exp_q[0].wdata));
            end
         end
         if (ack_o != 2'b00) begin
            if (exp_q.size() == 0) begin
               check("unexpected_ack", 64'(ack_o), 64'd0);
            end else begin
               e = exp_q.pop_front();
               check("ack_owner", 64'(ack_o), 64'(e.grant));
               check("resp_grant", 64'(grant_o), 64'(e.grant));
               check("rdata", 64'(rdata_o), 64'(e.rdata));
               check("strobe_cycles", 64'(strb_cnt), 64'(LAT));
               check("resp_bus_quiet", {30'd0, mem_read_o, mem_write_o, mem_addr_o}, 64'd0);
               if (chk_gap && last_ack_cyc >= 0)
                  check("ack_gap", 64'(cyc - last_ack_cyc), 64'(LAT + 2));
               last_ack_cyc = cyc;
            end
            strb_cnt = 0;
         end
      end
   end

   task automatic push(input bit port, input bit we, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] rv);
      exp_t e;
      e.grant = port ? 2'b10 : 2'b01;
      e.we    = we;
      e.addr  = a;
      e.wdata = wd;
      if (!we) exp_rdata = rv;
      e.rdata = exp_rdata;
      exp_q.push_back(e);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      exp_q.delete();
      exp_rdata = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic wait_ack(input string name);
      bit ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (ack_o != 2'b00) begin
            ok = 1'b1;
            break;
         end
      end
      check(name, 64'(ok), 64'd1);
   endtask

   task automatic txn(input bit port, input bit we, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] rv, input string name);
      mem_rdata = rv;
      push(port, we, a, wd, rv);
      @(negedge clk);
      if (port) begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = wd; end
      else      begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = wd; end
      wait_ack(name);
      req0 = 1'b0;
      req1 = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // 1: reset state, then a req0 read
      #2 rst = 1'b1;
      #1 check("reset_outs", {grant_o, ack_o, busy_o, mem_read_o, mem_write_o, 25'd0, rdata_o}, 64'd0);
      check("reset_bus", {mem_addr_o, mem_wdata_o}, 64'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      txn(1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, "t1_ack");

      // 2: req1 write; the capture value differs so a wrong rdata update would show
      txn(1'b1, 1'b1, 32'h04, 32'h12345678, 32'h55555555, "t2_ack");

      // 3: both requesters held high for four transactions from reset
      do_reset();
      chk_gap   = 1'b1;
      mem_rdata = 32'hCAFEF00D;
`ifdef DMEM_ARB_FIXED_PRIO_EN
      for (int i = 0; i < 4; i++) push(1'b0, 1'b0, 32'h100, 32'h0, 32'hCAFEF00D);
`else
      for (int i = 0; i < 2; i++) begin
         push(1'b0, 1'b0, 32'h100, 32'h0, 32'hCAFEF00D);
         push(1'b1, 1'b1, 32'h200, 32'hA5A5A5A5, 32'h0);
      end
`endif
      req0 = 1'b1; we0 = 1'b0; addr0 = 32'h100; wdata0 = 32'h0;
      req1 = 1'b1; we1 = 1'b1; addr1 = 32'h200; wdata1 = 32'hA5A5A5A5;
      for (int i = 0; i < 4; i++) wait_ack("t3_ack");
      req0 = 1'b0;
      req1 = 1'b0;
      chk_gap = 1'b0;
      repeat (2) @(negedge clk);
      check("t3_all_retired", 64'(exp_q.size()), 64'd0);

      // 4: req0 dropped and address changed after the grant
      mem_rdata = 32'h0BADF00D;
      push(1'b0, 1'b0, 32'h10, 32'h0, 32'h0BADF00D);
      @(negedge clk);
      req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10;
      @(negedge clk);
      check("t4_busy", 64'(busy_o), 64'd1);
      req0  = 1'b0;
      addr0 = 32'h20;
      wait_ack("t4_ack");
      @(negedge clk);

      // 5: reset in the second BUSY cycle aborts without an ack
      mem_rdata = 32'h11111111;
      req0 = 1'b1; we0 = 1'b0; addr0 = 32'h40;
      @(posedge clk);
      @(posedge clk);
      #1 check("t5_busy2", {62'd0, busy_o, mem_read_o}, 64'd3);
      #1 rst = 1'b1;
      #1 check("t5_abort", {58'd0, busy_o, grant_o, mem_read_o, mem_write_o, ack_o[0]}, 64'd0);
      req0 = 1'b0;
      exp_q.delete();
      exp_rdata = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      txn(1'b0, 1'b0, 32'h44, 32'h0, 32'h13572468, "t5_regrant");

      // 6: LATENCY=1 instance, single strobe cycle and ack right after it
      do_reset();
      mem_rdata = 32'h2468ACE0;
      push(1'b0, 1'b0, 32'h30, 32'h0, 32'h2468ACE0);
      req0 = 1'b1; we0 = 1'b0; addr0 = 32'h30;
      @(posedge clk);
      #1 check("t6_strobe", {26'd0, busy_b, grant_b, read_b, write_b, ack_b, mem_addr_b[6:0]},
               {26'd0, 1'b1, 2'b01, 1'b1, 1'b0, 2'b00, 7'h30});
      check("t6_wdata", 64'(mem_wdata_b), 64'd0);
      @(posedge clk);
      #1 check("t6_ack", {60'd0, ack_b, read_b, write_b}, {60'd0, 2'b01, 2'b00});
      check("t6_rdata", 64'(rdata_b), 64'h2468ACE0);
      @(posedge clk);
      #1 check("t6_ack_pulse", 64'(ack_b), 64'd0);
      req0 = 1'b0;
      wait_ack("t6_main_ack");
      repeat (2) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
